// File: rtl/link_pkg.sv
// -----------------------------------------------------------------------------
// link_pkg
// Shared definitions for the Link character block and its collision detector:
// direction codes, collision-map tile codes, collision result bit positions,
// screen/sprite geometry and the detector's internal state encoding.
// Optional build macro used by consumers: COLL_HAZARD_EN (hazard reporting).
// -----------------------------------------------------------------------------
package link_pkg;

   // Requested action/direction from the character block
   typedef enum logic [2:0] {
      NO_ACTION = 3'd0,
      ATTACK    = 3'd1,
      UP        = 3'd2,
      DOWN      = 3'd3,
      LEFT      = 3'd4,
      RIGHT     = 3'd5
   } dir_e;

   // Collision-map tile codes
   localparam logic [1:0] TILE_FREE   = 2'b00;
   localparam logic [1:0] TILE_WALL   = 2'b01;
   localparam logic [1:0] TILE_HAZARD = 2'b10;
   localparam logic [1:0] TILE_WATER  = 2'b11;

   // Collision result bits
   localparam int COLL_BLOCKED_BIT = 0;
   localparam int COLL_HAZARD_BIT  = 1;

   // Screen and sprite geometry
   localparam int SCREEN_W         = 320;
   localparam int SCREEN_H         = 240;
   localparam int SPRITE_PX        = 16;
   localparam int MAP_W_TILES_DFLT = SCREEN_W / SPRITE_PX;   // 20
   localparam int X_MAX_DFLT       = SCREEN_W - SPRITE_PX;   // 304
   localparam int Y_MAX_DFLT       = SCREEN_H - SPRITE_PX;   // 224
   localparam int ADDR_W_DFLT      = 9;

   // Collision detector sequencing
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE_B = 2'd1,
      S_CAP_A   = 2'd2,
      S_CAP_B   = 2'd3
   } coll_state_e;

   // Walls and water both stop movement; hazards are walkable
   function automatic logic tile_blocks(input logic [1:0] code);
      return (code == TILE_WALL) || (code == TILE_WATER);
   endfunction

endpackage

// File: rtl/coll_probe_addr.sv
// -----------------------------------------------------------------------------
// coll_probe_addr
// Combinational: picks one of the two leading-edge probe pixels for a move in
// the given direction and converts it into a collision-map tile address.
//   dir_i   : requested direction (link_pkg::dir_e encoding)
//   x_i/y_i : sprite top-left position
//   sel_i   : 0 selects probe P0, 1 selects probe P1
//   px_o/py_o : probe pixel coordinates (widened so edge offsets never wrap)
//   addr_o  : (py>>4)*MAP_W_TILES + (px>>4)
// -----------------------------------------------------------------------------
module coll_probe_addr
   import link_pkg::*;
#(
   parameter int MAP_W_TILES = MAP_W_TILES_DFLT,
   parameter int ADDR_W      = ADDR_W_DFLT
) (
   input  logic [2:0]        dir_i,
   input  logic [8:0]        x_i,
   input  logic [7:0]        y_i,
   input  logic              sel_i,
   output logic [9:0]        px_o,
   output logic [8:0]        py_o,
   output logic [ADDR_W-1:0] addr_o
);

   logic [9:0] x_w;
   logic [8:0] y_w;
   logic [5:0] tx;
   logic [4:0] ty;

   assign x_w = {1'b0, x_i};
   assign y_w = {1'b0, y_i};

   // P0 is the top/left end of the leading edge, P1 the bottom/right end
   always_comb begin
      px_o = x_w;
      py_o = y_w;
      case (dir_i)
         UP: begin
            px_o = sel_i ? x_w + 10'd15 : x_w;
            py_o = y_w - 9'd1;
         end
         DOWN: begin
            px_o = sel_i ? x_w + 10'd15 : x_w;
            py_o = y_w + 9'd16;
         end
         LEFT: begin
            px_o = x_w - 10'd1;
            py_o = sel_i ? y_w + 9'd15 : y_w;
         end
         RIGHT: begin
            px_o = x_w + 10'd16;
            py_o = sel_i ? y_w + 9'd15 : y_w;
         end
         default: ;
      endcase
   end

   assign tx = px_o[9:4];
   assign ty = py_o[8:4];

   // Row stride multiply as a constant shift-add; for 20 this reduces to
   // (ty<<4) + (ty<<2).
   always_comb begin
      addr_o = ADDR_W'(tx);
      for (int i = 0; i < 16; i++) begin
         if (MAP_W_TILES[i]) addr_o = addr_o + (ADDR_W'(ty) << i);
      end
   end

endmodule

// File: rtl/link_collision_detector.sv
// -----------------------------------------------------------------------------
// link_collision_detector
// On start, probes the leading edge of Link's 16x16 sprite against the screen
// bounds and the tile collision map and returns a 2-bit collision code.
//   clock, reset     : clock, synchronous active-high reset
//   start            : request pulse, sampled only when idle
//   link_x_pos/_y_pos: sprite top-left position
//   link_direction   : requested direction (link_pkg::dir_e)
//   map_addr / map_q : collision-map ROM port (1-cycle synchronous read)
//   collision        : bit0 blocked, bit1 hazard; held until the next result
//   busy             : map check in progress
//   check_done       : one-cycle pulse when collision is updated
// Build macro: COLL_HAZARD_EN -- when defined, bit1 reports hazard tiles;
// otherwise bit1 is 0 and hazard tiles read as free.
// -----------------------------------------------------------------------------
module link_collision_detector
   import link_pkg::*;
#(
   parameter int MAP_W_TILES = MAP_W_TILES_DFLT,
   parameter int X_MAX       = X_MAX_DFLT,
   parameter int Y_MAX       = Y_MAX_DFLT,
   parameter int ADDR_W      = ADDR_W_DFLT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [8:0]        link_x_pos,
   input  logic [7:0]        link_y_pos,
   input  logic [2:0]        link_direction,
   output logic [ADDR_W-1:0] map_addr,
   input  logic [1:0]        map_q,
   output logic [1:0]        collision,
   output logic              busy,
   output logic              check_done
);

   coll_state_e       state_q, state_d;
   logic [8:0]        x_q, x_d;
   logic [7:0]        y_q, y_d;
   logic [2:0]        dir_q, dir_d;
   logic [1:0]        code0_q, code0_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        coll_q, coll_d;
   logic              done_q, done_d;

   logic [2:0]        pr_dir;
   logic [8:0]        pr_x;
   logic [7:0]        pr_y;
   logic              pr_sel;
   logic [ADDR_W-1:0] pr_addr;
   logic [9:0]        unused_px;
   logic [8:0]        unused_py;

   logic              no_move;
   logic              out_of_bounds;
   logic [1:0]        map_result;

   // In IDLE the probe looks at the live inputs so P0 can be issued on the
   // start edge; afterwards it works from the latched copy.
   always_comb begin
      if (state_q == S_IDLE) begin
         pr_dir = link_direction;
         pr_x   = link_x_pos;
         pr_y   = link_y_pos;
         pr_sel = 1'b0;
      end else begin
         pr_dir = dir_q;
         pr_x   = x_q;
         pr_y   = y_q;
         pr_sel = 1'b1;
      end
   end

   coll_probe_addr #(
      .MAP_W_TILES (MAP_W_TILES),
      .ADDR_W      (ADDR_W)
   ) u_probe (
      .dir_i  (pr_dir),
      .x_i    (pr_x),
      .y_i    (pr_y),
      .sel_i  (pr_sel),
      .px_o   (unused_px),
      .py_o   (unused_py),
      .addr_o (pr_addr)
   );

   // Directions outside UP..RIGHT never move, so they take the no-action path
   always_comb begin
      no_move = !((link_direction == UP)   || (link_direction == DOWN) ||
                  (link_direction == LEFT) || (link_direction == RIGHT));
      out_of_bounds = ((link_direction == UP)    && (link_y_pos == 8'd0))           ||
                      ((link_direction == DOWN)  && (link_y_pos >= 8'(Y_MAX)))      ||
                      ((link_direction == LEFT)  && (link_x_pos == 9'd0))           ||
                      ((link_direction == RIGHT) && (link_x_pos >= 9'(X_MAX)));
   end

   // code1 is taken straight off map_q in CAP_B, the same edge that
   // registers the result.
   always_comb begin
      map_result = 2'b00;
      map_result[COLL_BLOCKED_BIT] = tile_blocks(code0_q) | tile_blocks(map_q);
`ifdef COLL_HAZARD_EN
      map_result[COLL_HAZARD_BIT]  = (code0_q == TILE_HAZARD) | (map_q == TILE_HAZARD);
`else
      map_result[COLL_HAZARD_BIT]  = 1'b0;
`endif
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      dir_d   = dir_q;
      code0_d = code0_q;
      addr_d  = addr_q;
      coll_d  = coll_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               x_d   = link_x_pos;
               y_d   = link_y_pos;
               dir_d = link_direction;
               if (no_move) begin
                  coll_d = 2'b00;
                  done_d = 1'b1;
               end else if (out_of_bounds) begin
                  coll_d = 2'b01;
                  done_d = 1'b1;
               end else begin
                  addr_d  = pr_addr;
                  state_d = S_ISSUE_B;
               end
            end
         end
         S_ISSUE_B: begin
            addr_d  = pr_addr;
            state_d = S_CAP_A;
         end
         S_CAP_A: begin
            code0_d = map_q;
            state_d = S_CAP_B;
         end
         S_CAP_B: begin
            coll_d  = map_result;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         dir_q   <= '0;
         code0_q <= '0;
         addr_q  <= '0;
         coll_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         dir_q   <= dir_d;
         code0_q <= code0_d;
         addr_q  <= addr_d;
         coll_q  <= coll_d;
         done_q  <= done_d;
      end
   end

   assign map_addr   = addr_q;
   assign collision  = coll_q;
   assign check_done = done_q;
   assign busy       = (state_q != S_IDLE);

endmodule
